// File: rtl/i2c_slave_ctrl_pkg.sv
// rtl/i2c_slave_ctrl_pkg.sv - shared types and constants for the I2C slave controller
package i2c_slave_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// rtl/i2c_slave_ctrl_if.sv - pin and byte-handshake bundle of the I2C slave controller
interface i2c_slave_ctrl_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       start_o;
  logic       stop_o;
  logic       addr_hit;
  logic       rw;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, start_o, stop_o, addr_hit, rw, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, start_o, stop_o, addr_hit, rw, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl_line_filter.sv
// rtl/i2c_slave_ctrl_line_filter.sv - 2-FF synchroniser, glitch filter and edge pulses for one pin
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  logic [1:0] sync_q;
  logic [2:0] cnt_q;

  // Preset to 1 so an idle bus out of reset never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      line_f <= 1'b1;
      cnt_q  <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync_q[1] == line_f) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q  <= '0;
        line_f <= sync_q[1];
        rise   <= sync_q[1];
        fall   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - I2C slave bit/byte protocol sequencer with address match and ACK control
module i2c_slave_ctrl
  import i2c_slave_ctrl_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input logic             clk,
  input logic             rst,
  i2c_slave_ctrl_if.slave bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (bus.scl_i),
    .line_f (scl_f),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (bus.sda_i),
    .line_f (sda_f),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  // Simultaneous SCL and SDA edges are treated as data, never as bus conditions.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_f & ~scl_rise & ~scl_fall;
  assign stop_det  = sda_rise & scl_f & ~scl_rise & ~scl_fall;

  i2c_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       acked_q, acked_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       hit_q, hit_d;
  logic       rxv_q, rxv_d;
  logic       txr_q, txr_d;
  logic [7:0] byte_in;

  assign byte_in = {shift_q, sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      acked_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      hit_q     <= 1'b0;
      rxv_q     <= 1'b0;
      txr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      acked_q   <= acked_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      hit_q     <= hit_d;
      rxv_q     <= rxv_d;
      txr_q     <= txr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    acked_d   = acked_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    hit_d     = 1'b0;
    rxv_d     = 1'b0;
    txr_d     = 1'b0;

    if (stop_det) begin
      stop_d    = 1'b1;
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      start_d   = 1'b1;
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                hit_d   = 1'b1;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        // sda_oe doubles as the "ACK bit in progress" marker for the ACK states.
        ADDR_ACK: begin
          if (scl_rise && sda_oe_q && rw_q) begin
            txr_d = 1'b1;
          end else if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              shift_d  = bus.tx_data[6:0];
              sda_oe_d = ~bus.tx_data[7];
              state_d  = TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d = byte_in;
              rxv_d     = 1'b1;
              state_d   = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX;
            end
          end
        end
        TX: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              acked_d  = 1'b0;
              state_d  = TX_ACK;
            end else begin
              shift_d  = {shift_q[5:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_f == I2C_ACK) begin
              txr_d   = 1'b1;
              acked_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && acked_q) begin
            shift_d  = bus.tx_data[6:0];
            sda_oe_d = ~bus.tx_data[7];
            acked_d  = 1'b0;
            state_d  = TX;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.start_o  = start_q;
  assign bus.stop_o   = stop_q;
  assign bus.addr_hit = hit_q;
  assign bus.rw       = rw_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rxv_q;
  assign bus.tx_req   = txr_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - directed bus-level bench for the I2C slave controller
module tb_i2c_slave_ctrl;
  import i2c_slave_ctrl_pkg::*;

  localparam int Q = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int n_checks = 0;
  int n_pass = 0;

  int n_start = 0, n_stop = 0, n_hit = 0, n_rxv = 0, n_txr = 0, n_oe = 0;
  logic [7:0] rx_log [$];
  logic last_rw = 1'b0;
  int tx_idx = 0;
  logic [7:0] tx_tab [8] = '{8'h96, 8'h5A, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  i2c_slave_ctrl_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start_o)  n_start++;
    if (bus.stop_o)   n_stop++;
    if (bus.addr_hit) begin n_hit++; last_rw = bus.rw; end
    if (bus.rx_valid) begin n_rxv++; rx_log.push_back(bus.rx_data); end
    if (bus.sda_oe)   n_oe++;
    if (rst) bus.tx_data = 8'h00;
    else if (bus.tx_req) begin
      n_txr++;
      bus.tx_data = tx_tab[tx_idx % 8];
      tx_idx++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; waitc(Q);
    scl_m = 1'b1; waitc(2*Q);
    sda_m = 1'b0; waitc(2*Q);
    scl_m = 1'b0; waitc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; waitc(Q);
    scl_m = 1'b1; waitc(2*Q);
    sda_m = 1'b1; waitc(2*Q);
  endtask

  task automatic rd_bit(output logic v);
    sda_m = 1'b1; waitc(Q);
    scl_m = 1'b1; waitc(Q);
    v = bus.sda_i; waitc(Q);
    scl_m = 1'b0; waitc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; waitc(Q);
      scl_m = 1'b1; waitc(2*Q);
      scl_m = 1'b0; waitc(Q);
    end
    rd_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(v);
      b[i] = v;
    end
    sda_m = ack; waitc(Q);
    scl_m = 1'b1; waitc(2*Q);
    scl_m = 1'b0; waitc(Q);
    sda_m = 1'b1;
  endtask

  initial begin
    logic a0, a1, a2, v;
    logic [7:0] b1, b2;
    int s0, p0, h0, r0, t0, o0, base;

    waitc(5);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rw", bus.rw, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    waitc(10);
    chk("rst_no_pulses", n_start + n_stop + n_hit + n_rxv + n_txr, 0);

    // Write 0xA0, 0x3C, 0xC3
    s0 = n_start; p0 = n_stop; h0 = n_hit; r0 = n_rxv; base = rx_log.size();
    i2c_start();
    wr_byte(8'hA0, a0);
    chk("wr_busy", bus.busy, 1);
    wr_byte(8'h3C, a1);
    wr_byte(8'hC3, a2);
    i2c_stop();
    chk("wr_start", n_start - s0, 1);
    chk("wr_hit", n_hit - h0, 1);
    chk("wr_rw", last_rw, 0);
    chk("wr_ack_addr", a0, I2C_ACK);
    chk("wr_ack_b1", a1, I2C_ACK);
    chk("wr_ack_b2", a2, I2C_ACK);
    chk("wr_rxv", n_rxv - r0, 2);
    chk("wr_rx0", rx_log[base], 8'h3C);
    chk("wr_rx1", rx_log[base+1], 8'hC3);
    chk("wr_stop", n_stop - p0, 1);
    chk("wr_busy_end", bus.busy, 0);

    // Address 0x51 mismatch
    h0 = n_hit; o0 = n_oe; r0 = n_rxv;
    i2c_start();
    wr_byte(8'hA2, a0);
    wr_byte(8'h11, a1);
    wr_byte(8'h22, a2);
    chk("mm_nack", a0, I2C_NACK);
    chk("mm_state", 32'(dut.state_q), 32'(WAIT_STOP));
    i2c_stop();
    chk("mm_hit", n_hit - h0, 0);
    chk("mm_oe", n_oe - o0, 0);
    chk("mm_rxv", n_rxv - r0, 0);
    chk("mm_idle", 32'(dut.state_q), 32'(IDLE));

    // Read 0x96, 0x5A with ACK then NACK
    t0 = n_txr;
    i2c_start();
    wr_byte(8'hA1, a0);
    chk("rd_ack_addr", a0, I2C_ACK);
    chk("rd_rw", last_rw, 1);
    rd_byte(b1, I2C_ACK);
    chk("rd_busy_mid", bus.busy, 1);
    rd_byte(b2, I2C_NACK);
    chk("rd_byte0", b1, 8'h96);
    chk("rd_byte1", b2, 8'h5A);
    chk("rd_txreq", n_txr - t0, 2);
    chk("rd_busy_nack", bus.busy, 0);
    chk("rd_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
    i2c_stop();

    // Write then repeated START into a read
    s0 = n_start; h0 = n_hit;
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h01, a1);
    chk("rs_busy_pre", bus.busy, 1);
    i2c_start();
    chk("rs_busy_rs", bus.busy, 1);
    wr_byte(8'hA1, a2);
    chk("rs_ack", a2, I2C_ACK);
    chk("rs_start", n_start - s0, 2);
    chk("rs_hit", n_hit - h0, 2);
    chk("rs_rw", last_rw, 1);
    rd_byte(b1, I2C_NACK);
    chk("rs_byte", b1, 8'h77);
    i2c_stop();

    // SDA glitches with SCL high
    s0 = n_start; p0 = n_stop;
    sda_m = 1'b0; waitc(1); sda_m = 1'b1; waitc(20);
    sda_m = 1'b0; waitc(2); sda_m = 1'b1; waitc(20);
    chk("gl_no_start", n_start - s0, 0);
    chk("gl_no_stop", n_stop - p0, 0);
    sda_m = 1'b0; waitc(3); sda_m = 1'b1; waitc(4);
    chk("gl_start3", n_start - s0, 1);
    chk("gl_stop_pending", n_stop - p0, 0);
    waitc(20);
    chk("gl_idle", 32'(dut.state_q), 32'(IDLE));

    // Reset during bit 4 of a read byte (tx byte 0x00 keeps SDA driven low)
    i2c_start();
    wr_byte(8'hA1, a0);
    chk("rr_ack", a0, I2C_ACK);
    for (int i = 0; i < 3; i++) rd_bit(v);
    sda_m = 1'b1; waitc(Q);
    scl_m = 1'b1; waitc(Q);
    chk("rr_oe_pre", bus.sda_oe, 1);
    s0 = n_start; p0 = n_stop; h0 = n_hit; r0 = n_rxv; t0 = n_txr;
    rst = 1'b1; waitc(1);
    chk("rr_oe_post", bus.sda_oe, 0);
    chk("rr_busy_post", bus.busy, 0);
    chk("rr_state_post", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0; waitc(Q);
    chk("rr_no_pulses", (n_start - s0) + (n_stop - p0) + (n_hit - h0) + (n_rxv - r0) + (n_txr - t0), 0);
    scl_m = 1'b0; waitc(Q);
    i2c_stop();

    h0 = n_hit; r0 = n_rxv; base = rx_log.size();
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h5A, a1);
    i2c_stop();
    chk("rr_wr_hit", n_hit - h0, 1);
    chk("rr_wr_acks", {a0, a1}, 2'b00);
    chk("rr_wr_rxv", n_rxv - r0, 1);
    chk("rr_wr_data", rx_log[base], 8'h5A);
    chk("rr_wr_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

Bit- and byte-level protocol controller for the I2C slave. Synchronises and de-glitches the raw SCL/SDA pins, turns their edges into START/STOP/bit events, and sequences address match, ACK generation and byte shifting in both directions. It sits between the pad buffers and the register-file front end, which sees only byte-wide rx/tx handshakes.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit slave address matched after START.
- FILTER_LEN, 3: number of consecutive identical synchronised samples required before a filtered line changes value (1..7).

Ports:
- clk  in  1  system clock, at least 20x SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  raw SCL pin, asynchronous.
- sda_i  in  1  raw SDA pin, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. Open-drain enable.
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- addr_hit  out  1  one-cycle pulse when the received address equals SLAVE_ADDR.
- rw  out  1  R/W bit of the last matched address (1 = read), held until the next addr_hit.
- rx_data  out  8  last received write byte, held until overwritten.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- tx_data  in  8  byte to transmit on a read.
- tx_req  out  1  one-cycle pulse requesting the next tx_data.
- busy  out  1  high from addressed START until STOP or NACK-terminated read.

## Operation
- Line conditioning: each pin passes through a 2-FF synchroniser, then a FILTER_LEN saturating counter; scl_f/sda_f are the filtered values, and scl_rise/scl_fall/sda_rise/sda_fall are one-cycle pulses on filtered transitions.
- START: sda_fall while scl_f = 1 and no scl edge in the same cycle. STOP: sda_rise under the same condition. SDA and SCL edges in the same cycle count as data, never as START/STOP.
- Bits are sampled on scl_rise. SDA is driven or changed only on scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits, MSB first. After the 8th scl_rise:
    - match -> pulse addr_hit, latch rw, set busy, then ADDR_ACK;
    - mismatch -> WAIT_STOP, no ACK.
  - ADDR_ACK: sda_oe = 1 from the next scl_fall to the following scl_fall.
    - rw = 0 -> RX.
    - rw = 1 -> pulse tx_req on the ACK-bit scl_rise; at the ending scl_fall, load tx_data into the shift register and drive the MSB; then TX.
  - RX: 8 bits; on the 8th scl_rise, update rx_data and pulse rx_valid; then RX_ACK. Every data byte is ACKed. RX_ACK returns to RX.
  - TX: sda_oe = ~bit for 8 bits; release at the scl_fall after bit 0; then TX_ACK.
  - TX_ACK: sample master ACK on scl_rise.
    - 0 -> pulse tx_req; at the next scl_fall, load and drive the next byte; then TX.
    - 1 (NACK) -> clear busy, WAIT_STOP.
  - WAIT_STOP: sda_oe = 0; wait for STOP or START.
- START in any state: restart ADDR, clear bit counter, sda_oe = 0 on the next cycle. busy stays set until STOP.
- STOP in any state: go to IDLE, sda_oe = 0, busy = 0.
- The bit counter is 3 bits and wraps 7 -> 0 at byte end. No other arithmetic.

## Timing
- Reset values: sda_oe, start_o, stop_o, addr_hit, rx_valid, tx_req, busy, rw = 0; rx_data = 8'h00. FSM = IDLE; filters preset to 1 (idle bus).
- Latency from a raw pin change to its edge pulse: 2 + FILTER_LEN clk cycles. Pulses of FILTER_LEN-1 cycles or shorter are rejected.
- Status pulses (start_o, stop_o, addr_hit, rx_valid, tx_req) are registered and appear 1 cycle after the qualifying edge pulse.
- sda_oe changes 1 cycle after scl_fall.
- tx_data must be stable from the cycle after tx_req until the next scl_fall; it is sampled exactly then.
- rst asserted mid-transfer: all outputs take reset values on the next clk edge, SDA is released, and no pulses are emitted.

## Structure
- Shared package: FSM state enum `i2c_state_t`, `I2C_ACK = 1'b0`, `I2C_NACK = 1'b1`.
- One sub-module, `i2c_line_filter`, instantiated twice (SCL, SDA): synchroniser, FILTER_LEN glitch filter, rise/fall pulses, sync active-high reset. The FSM and shift register stay in `i2c_slave_ctrl`.

## Test plan
- Write 0xA0, 0x3C, 0xC3 with STOP → addr_hit = 1 with rw = 0. rx_valid pulses twice, with rx_data 0x3C then 0xC3. SDA is low on all three ACK bits. stop_o pulses once and busy then drops.
- Address 0x51 (mismatch) then 2 bytes → no addr_hit, sda_oe stays 0 throughout, FSM waits in WAIT_STOP, and STOP returns it to IDLE.
- Read 0xA1 with tx_data 0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2 → bus carries 0x96 then 0x5A. tx_req pulses twice and busy clears at the NACK.
- Write 0xA0, 0x01, then repeated START and 0xA1 → start_o pulses twice and the second addr_hit shows rw = 1. busy never drops between the two.
- 1-cycle SDA glitch while SCL is high (FILTER_LEN = 3) → no start_o or stop_o. A 3-cycle SDA low is accepted as a START.
- rst pulse during bit 4 of a read byte → sda_oe = 0 on the next cycle. A subsequent full write transaction completes normally.
